// File: rtl/bfcpu_uart_tx_if.sv
// Byte handshake between the CPU output path and the UART transmitter.
// Latency: none, plain wires.
// Backpressure: producer holds tx_valid_i/tx_data_i until a posedge sees tx_ready_o high.
interface bfcpu_uart_tx_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;

    modport master (output tx_data_i, output tx_valid_i, input  tx_ready_o);
    modport slave  (input  tx_data_i, input  tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/bfcpu_uart_tx.sv
// 8N1 UART transmitter, LSB first; BFCPU_UART_TX_FIFO_EN swaps the holding register for a FIFO_DEPTH FIFO.
// Latency: a byte accepted while idle and empty drives the start bit from the next posedge; frame = 10*(div+1) clk.
// Backpressure: tx_ready_o is registered and drops when storage is full (2 bytes, or 1+FIFO_DEPTH with the FIFO).
module bfcpu_uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      div_i,
    bfcpu_uart_tx_if.slave   tx,
    output logic             txd_o,
    output logic             busy_o,
    output logic             tx_done_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] bit_div;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shifter;

    logic        pending;
    logic [7:0]  head_dat;
    logic        push;
    logic        pop;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    assign push = tx.tx_valid_i & tx.tx_ready_o;
    // The shifter takes the next byte either from idle or on the last stop-bit cycle.
    assign pop  = pending & ((state == IDLE) | ((state == STOP) & (cnt == 16'd0)));

`ifdef BFCPU_UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [AW:0] count_nxt;

    assign count     = wr_ptr - rd_ptr;
    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign pending   = (count != '0);
    assign head_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx.tx_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tx.tx_ready_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            tx.tx_ready_o <= (count_nxt != (AW+1)'(FIFO_DEPTH));
        end
    end
`else
    logic       hold_vld;
    logic [7:0] hold_dat;

    assign pending  = hold_vld;
    assign head_dat = hold_dat;

    // Push only happens while empty and pop only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld      <= 1'b0;
            hold_dat      <= 8'h00;
            tx.tx_ready_o <= 1'b1;
        end else if (push) begin
            hold_vld      <= 1'b1;
            hold_dat      <= tx.tx_data_i;
            tx.tx_ready_o <= 1'b0;
        end else if (pop) begin
            hold_vld      <= 1'b0;
            tx.tx_ready_o <= 1'b1;
        end
    end
`endif

    assign busy_o = (state != IDLE) | pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            txd_o     <= 1'b1;
            tx_done_o <= 1'b0;
            bit_div   <= 16'd0;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shifter   <= 8'h00;
        end else begin
            tx_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        shifter <= head_dat;
                        bit_div <= div_i;
                        cnt     <= div_i;
                        txd_o   <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt == 16'd0) begin
                        cnt     <= bit_div;
                        bit_idx <= 3'd0;
                        txd_o   <= shifter[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= bit_div;
                        if (bit_idx == 3'd7) begin
                            txd_o     <= 1'b1;
                            state     <= STOP;
                            tx_done_o <= (bit_div == 16'd0);
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_o   <= shifter[1];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == 16'd0) begin
                        if (pending) begin
                            shifter <= head_dat;
                            bit_div <= div_i;
                            cnt     <= div_i;
                            txd_o   <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt       <= cnt - 16'd1;
                        tx_done_o <= (cnt == 16'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bfcpu_uart_tx.sv
// Randomised scoreboard bench for bfcpu_uart_tx: accepted bytes are queued, a line monitor rebuilds
// each frame from 8N1 rules and compares every clk of txd_o and tx_done_o.
module tb_bfcpu_uart_tx;
`ifdef BFCPU_UART_TX_FIFO_EN
    localparam int CAP = 5;
`else
    localparam int CAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] div_i;
    logic        txd_o;
    logic        busy_o;
    logic        tx_done_o;

    bfcpu_uart_tx_if tx_if ();

    bfcpu_uart_tx #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_i     (div_i),
        .tx        (tx_if.slave),
        .txd_o     (txd_o),
        .busy_o    (busy_o),
        .tx_done_o (tx_done_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          frames_ok = 0;
    int          done_cnt = 0;
    int          last_gap = 0;
    int          last_start = 0;
    int          last_end = -100;
    bit          in_frame = 1'b0;
    logic [15:0] div_q = 16'd0;
    logic [7:0]  exp_q [$];
    int          len_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) div_q <= div_i;
    always @(negedge clk) if (tx_done_o === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference frame: bit slot 0 is start (0), slots 1..8 are data LSB first, slot 9 is stop (1).
    task automatic run_frame();
        logic [7:0] e;
        int         p;
        int         mism;
        int         dbad;
        int         bi;
        logic       eb;
        bit         ab;
        mism = 0; dbad = 0; ab = 1'b0; e = 8'h00;
        in_frame   = 1'b1;
        last_gap   = cyc - last_end - 1;
        last_start = cyc;
        chk("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        p = int'(div_q) + 1;
        for (int k = 0; k < 10 * p; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    ab = 1'b1;
                    break;
                end
            end
            bi = k / p;
            eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e[bi-1];
            if (txd_o !== eb) mism++;
            if (tx_done_o !== (k == 10 * p - 1)) dbad++;
        end
        if (!ab) begin
            chk("frame_bits", mism, 0);
            chk("frame_done", dbad, 0);
            frames_ok++;
            last_end = cyc;
            len_q.push_back(last_end - last_start + 1);
        end
        in_frame = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (txd_o === 1'b0) run_frame();
                else chk("idle_done", int'(tx_done_o), 0);
            end
        end
    end

    task automatic send(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        tx_if.tx_valid_i = 1'b1;
        tx_if.tx_data_i  = b;
        while (tx_if.tx_ready_o !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            chk("accept_timeout", 1, 0);
            acc = -1;
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
            #1 acc = cyc;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        tx_if.tx_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy_o !== 1'b0 || in_frame) && n < 20000);
        chk({name, "_drain_timeout"}, int'(n >= 20000), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, f0, n;
        int acc [6];
        rst_n = 1'b0;
        div_i = 16'd3;
        tx_if.tx_valid_i = 1'b0;
        tx_if.tx_data_i  = 8'h00;
        #12;
        chk("reset_txd",   int'(txd_o), 1);
        chk("reset_ready", int'(tx_if.tx_ready_o), 1);
        chk("reset_busy",  int'(busy_o), 0);
        chk("reset_done",  int'(tx_done_o), 0);
        #20 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte from idle.
        f0 = frames_ok;
        send(8'hA5, a0);
        chk("t1_busy", int'(busy_o), 1);
        chk("t1_ready", int'(tx_if.tx_ready_o), (CAP > 2) ? 1 : 0);
        idle();
        drain("t1");
        chk("t1_latency", last_start - a0, 1);
        chk("t1_frames", frames_ok - f0, 1);
        chk("t1_len", len_q[$], 40);

        // Two bytes offered back to back must come out without an idle gap.
        f0 = frames_ok;
        send(8'h55, a0);
        send(8'hAA, a1);
        idle();
        drain("t2");
        chk("t2_frames", frames_ok - f0, 2);
        chk("t2_gap", last_gap, 0);
        chk("t2_len", len_q[$], 40);

        // Valid held: storage fills, next byte waits for the first frame's stop bit.
        f0 = frames_ok;
        for (int i = 0; i <= CAP; i++) send(8'h10 + 8'(i), acc[i]);
        idle();
        drain("t3");
        chk("t3_second", acc[1] - acc[0], (CAP > 2) ? 1 : 2);
        chk("t3_stall", acc[CAP] - acc[0], 42);
        chk("t3_frames", frames_ok - f0, CAP + 1);

        // Divisor change mid-frame only affects the following frame.
        @(negedge clk) div_i = 16'h0202;
        send(8'h3C, a0);
        idle();
        repeat (1000) @(negedge clk);
        div_i = 16'd5;
        send(8'hC3, a1);
        idle();
        drain("t4");
        chk("t4_len_first", len_q[$-1], 5150);
        chk("t4_len_second", len_q[$], 60);
        chk("t4_gap", last_gap, 0);

        // Reset during data bit 3 with a second byte pending.
        @(negedge clk) div_i = 16'd3;
        repeat (2) @(negedge clk);
        f0 = frames_ok;
        send(8'h5A, a0);
        send(8'h11, a1);
        idle();
        n = 0;
        while (cyc < a0 + 18 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_txd_in_reset", int'(txd_o), 1);
        exp_q.delete();
        #20 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_busy", int'(busy_o), 0);
        chk("t5_ready", int'(tx_if.tx_ready_o), 1);
        chk("t5_txd", int'(txd_o), 1);
        repeat (60) @(negedge clk);
        chk("t5_no_frames", frames_ok - f0, 0);

        // Random bytes, divisors and gaps.
        f0 = frames_ok;
        for (int r = 0; r < 24; r++) begin
            if (r % 6 == 0) begin
                idle();
                drain("rnd");
                div_i = 16'($urandom_range(0, 4));
            end
            send(8'($urandom), a0);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end
        end
        idle();
        drain("rnd_end");
        chk("rnd_frames", frames_ok - f0, 24);

        chk("queue_empty", exp_q.size(), 0);
        chk("done_pulses", done_cnt, frames_ok);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
